rs_encoder: RTL and testbench

Parametrised systematic Reed-Solomon encoder over GF(2^8) for the WiMAX OFDM FEC chain. It sits between the randomizer and the convolutional encoder. Data symbols pass through unchanged, then 2·t_sel parity symbols are appended. Parity is computed for a fixed-generator RS(255,255−2·T_MAX) mother code and punctured to the first 2·t_sel symbols, so variable-T operation and shortened blocks use one datapath. Full valid/ready handshake on both sides, with block framing via last flags.

---
 rtl/rs_encoder_pkg.sv | 50 +++++
 rtl/rs_encoder_gf_const_mult.sv | 15 +
 rtl/rs_encoder.sv | 127 ++++++++++++
 tb/tb_rs_encoder.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_encoder_pkg.sv
// Shared definitions for the Reed-Solomon encoder over GF(2^8).
//   PRIM_POLY / LAMBDA : field polynomial and primitive element
//   gf_mul             : GF(2^8) multiply, reduced by a field polynomial
//   gf_pow             : LAMBDA raised to an integer power
//   gen_coef           : coefficient g_i of the monic generator polynomial
//   state_t            : encoder state {DATA, PARITY}
package rs_pkg;

  localparam logic [8:0] PRIM_POLY = 9'h11D;
  localparam logic [7:0] LAMBDA    = 8'h02;

  typedef enum logic {DATA = 1'b0, PARITY = 1'b1} state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b,
                                        input logic [8:0] poly = PRIM_POLY);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ poly[7:0]) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_pow(input int e, input logic [8:0] poly = PRIM_POLY);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 0; k < e; k++) r = gf_mul(r, LAMBDA, poly);
    return r;
  endfunction

  // g(x) = prod_{k=0}^{2*t_max-1} (x + LAMBDA^(fcr+k)); evaluated at elaboration.
  // Degree is at most 16, so a 17-entry coefficient vector is enough.
  function automatic logic [7:0] gen_coef(input int t_max, input int fcr, input int i,
                                          input logic [8:0] poly = PRIM_POLY);
    logic [16:0][7:0] g;
    logic [7:0]       root;
    g    = '0;
    g[0] = 8'h01;
    for (int k = 0; k < 2 * t_max; k++) begin
      root = gf_pow(fcr + k, poly);
      for (int j = 16; j > 0; j--) g[j] = g[j-1] ^ gf_mul(g[j], root, poly);
      g[0] = gf_mul(g[0], root, poly);
    end
    return g[i];
  endfunction

endpackage

// File: rtl/rs_encoder_gf_const_mult.sv
// Combinational multiply of a GF(2^8) symbol by an elaboration-time constant.
//   a : input symbol
//   y : a * C, reduced by POLY
module gf_const_mult import rs_pkg::*; #(
  parameter logic [7:0] C    = 8'h01,
  parameter logic [8:0] POLY = 9'h11D
) (
  input  logic [7:0] a,
  output logic [7:0] y
);

  // With C constant the function's loop collapses to an XOR network.
  assign y = gf_mul(a, C, POLY);

endmodule

// File: rtl/rs_encoder.sv
// Systematic RS encoder over GF(2^8). Information symbols pass through, then
// 2*t_sel parity symbols from the RS(255,255-2*T_MAX) mother code follow,
// taken from the top of the parity register (puncturing the rest).
//   clk, reset                  : clock, synchronous active-high reset
//   in_data/valid/last/ready    : information symbol stream
//   t_sel                       : parity pairs, sampled on a block's first symbol
//   out_data/valid/last/parity  : registered codeword stream, out_ready backpressure
//   len_err                     : one-cycle pulse when a block is too long
module rs_encoder import rs_pkg::*; #(
  parameter int         W         = 8,
  parameter int         T_MAX     = 8,
  parameter logic [8:0] PRIM_POLY = 9'h11D,
  parameter int         FCR       = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  input  logic [3:0]   t_sel,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  output logic         out_last,
  output logic         out_parity,
  input  logic         out_ready,
  output logic         len_err
);

  localparam int         NP      = 2 * T_MAX;
  localparam logic [7:0] LEN_LIM = 8'(255 - NP);

  logic [NP-1:0][W-1:0] b;
  logic [NP-1:0][W-1:0] prod;
  state_t               state;
  logic [3:0]           t_lat;
  logic [4:0]           par_cnt;
  logic [7:0]           blk_cnt;

  logic                 slot_free;
  logic                 accept;
  logic [W-1:0]         fb;
  logic [3:0]           t_clamp;
  logic [3:0]           t_cur;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (state == DATA) && slot_free;
  assign accept    = in_valid && in_ready;
  assign fb        = in_data ^ b[NP-1];
  assign t_clamp   = (t_sel > 4'(T_MAX)) ? 4'(T_MAX) : t_sel;
  // A one-symbol block must use this cycle's t_sel, not the stale latch.
  assign t_cur     = (blk_cnt == 8'd0) ? t_clamp : t_lat;

  for (genvar i = 0; i < NP; i++) begin : g_mul
    gf_const_mult #(
      .C    (gen_coef(T_MAX, FCR, i, PRIM_POLY)),
      .POLY (PRIM_POLY)
    ) u_mul (
      .a (fb),
      .y (prod[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      b          <= '0;
      state      <= DATA;
      t_lat      <= '0;
      par_cnt    <= '0;
      blk_cnt    <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_parity <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      len_err <= 1'b0;
      // Drain; any load below overrides.
      if (slot_free) begin
        out_valid  <= 1'b0;
        out_last   <= 1'b0;
        out_parity <= 1'b0;
      end
      case (state)
        DATA: if (accept) begin
          out_data   <= in_data;
          out_valid  <= 1'b1;
          out_parity <= 1'b0;
          out_last   <= 1'b0;
          b[0]       <= prod[0];
          for (int i = 1; i < NP; i++) b[i] <= b[i-1] ^ prod[i];
          if (blk_cnt == 8'd0) t_lat <= t_clamp;
          if (blk_cnt != 8'hFF) blk_cnt <= blk_cnt + 8'd1;
          len_err <= (blk_cnt == LEN_LIM);
          if (in_last) begin
            if (t_cur == 4'd0) begin
              // No parity: close the block here and drop the remainder so
              // the next block starts from a clean register.
              out_last <= 1'b1;
              blk_cnt  <= '0;
              b        <= '0;
            end else begin
              state   <= PARITY;
              par_cnt <= {t_cur, 1'b0};
            end
          end
        end
        PARITY: if (slot_free) begin
          out_data   <= b[NP-1];
          out_valid  <= 1'b1;
          out_parity <= 1'b1;
          out_last   <= 1'b0;
          b          <= {b[NP-2:0], W'(0)};
          par_cnt    <= par_cnt - 5'd1;
          if (par_cnt == 5'd1) begin
            out_last <= 1'b1;
            b        <= '0;
            blk_cnt  <= '0;
            state    <= DATA;
          end
        end
        default: state <= DATA;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_encoder.sv
module tb_rs_encoder;

  localparam int T  = 8;
  localparam int NP = 2 * T;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid, in_last, in_ready;
  logic [3:0] t_sel;
  logic [7:0] out_data;
  logic       out_valid, out_last, out_parity, out_ready, len_err;

  rs_encoder #(.W(8), .T_MAX(T), .PRIM_POLY(9'h11D), .FCR(0)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .t_sel(t_sel),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_parity(out_parity), .out_ready(out_ready), .len_err(len_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    bit last, par, dc, first, syn;
  } exp_t;

  exp_t       q[$];
  logic [7:0] cw[$];
  int checks = 0, failures = 0;
  int cyc = 0, first_cyc = 0, last_cyc = 0, len_pulses = 0;
  int rdy_mode = 2;
  bit mon_en = 1'b1;
  bit stall = 1'b0;
  logic [7:0] hd;
  logic hl, hp;

  logic [7:0] gexp[0:255];
  int         glog[0:255];
  logic [7:0] g[0:16];
  logic [7:0] blk[0:255];

  always @(posedge clk) cyc++;

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'd0 || b == 8'd0) return 8'd0;
    return gexp[(glog[a] + glog[b]) % 255];
  endfunction

  task automatic build_field();
    int x;
    x = 1;
    for (int i = 0; i < 255; i++) begin
      gexp[i] = 8'(x);
      glog[x] = i;
      x = x << 1;
      if (x > 255) x = x ^ 'h11D;
    end
    gexp[255] = gexp[0];
    for (int j = 0; j <= 16; j++) g[j] = 8'd0;
    g[0] = 8'd1;
    for (int k = 0; k < NP; k++) begin
      for (int j = 16; j > 0; j--) g[j] = g[j-1] ^ mul(g[j], gexp[k]);
      g[0] = mul(g[0], gexp[k]);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Codeword evaluated at every generator root must vanish.
  function automatic bit syn_ok();
    logic [7:0] s;
    for (int j = 0; j < NP; j++) begin
      s = 8'd0;
      foreach (cw[k]) s = mul(s, gexp[j]) ^ cw[k];
      if (s != 8'd0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (len_err) len_pulses++;
    if (reset) begin
      stall = 1'b0;
      cw.delete();
    end else begin
      if (stall) begin
        chk("hold_valid",  32'(out_valid),  32'd1);
        chk("hold_data",   32'(out_data),   32'(hd));
        chk("hold_last",   32'(out_last),   32'(hl));
        chk("hold_parity", 32'(out_parity), 32'(hp));
      end
      stall = out_valid && !out_ready;
      hd = out_data; hl = out_last; hp = out_parity;
      if (mon_en && out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL extra_output: got %0h expected none", out_data);
        end else begin
          e = q.pop_front();
          if (!e.dc) chk("out_data", 32'(out_data), 32'(e.d));
          chk("out_last",   32'(out_last),   32'(e.last));
          chk("out_parity", 32'(out_parity), 32'(e.par));
          if (e.first) first_cyc = cyc;
          if (e.last) last_cyc = cyc;
          cw.push_back(out_data);
          if (out_last) begin
            if (e.syn) chk("syndrome_zero", 32'(syn_ok()), 32'd1);
            cw.delete();
          end
        end
      end
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Expected codeword = data followed by the first 2*t of (m(x)*x^16 mod g(x)),
  // highest-degree remainder coefficient first.
  task automatic send(input int n, input int tsel, input bit gaps, input bit lenblk, input bit push);
    logic [7:0] dv[0:271];
    logic [7:0] c;
    exp_t e;
    int te, guard;
    bit acc;
    te = (tsel > T) ? T : tsel;
    for (int i = 0; i < n + NP; i++) dv[i] = (i < n) ? blk[i] : 8'd0;
    for (int i = 0; i < n; i++) begin
      c = dv[i];
      if (c != 8'd0)
        for (int j = 1; j <= NP; j++) dv[i+j] = dv[i+j] ^ mul(c, g[NP-j]);
    end
    if (push) begin
      for (int i = 0; i < n; i++) begin
        e.d = blk[i]; e.last = (te == 0 && i == n-1); e.par = 0; e.dc = 0;
        e.first = (i == 0); e.syn = 0;
        q.push_back(e);
      end
      for (int k = 0; k < 2*te; k++) begin
        e.d = dv[n+k]; e.last = (k == 2*te-1); e.par = 1; e.dc = lenblk;
        e.first = 0; e.syn = (k == 2*te-1) && (te == T) && !lenblk;
        q.push_back(e);
      end
    end
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = blk[i];
      in_last  = (i == n-1);
      t_sel    = (i == 0) ? 4'(tsel) : 4'($urandom_range(0, 15));
      acc = 1'b0; guard = 0;
      while (!acc) begin
        @(negedge clk); acc = in_ready;
        @(posedge clk); #1;
        guard++;
        if (guard > 2000) begin
          checks++; failures++;
          $display("FAIL accept_timeout: symbol %0d never accepted", i);
          in_valid = 1'b0;
          return;
        end
      end
      chk("len_err", 32'(len_err), 32'(lenblk && i == 255 - NP));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 5000) begin
      @(posedge clk); guard++;
    end
    #1;
    if (q.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input int m);
    rdy_mode = m;
    @(posedge clk); #1;
  endtask

  initial begin
    int n, pc, guard;
    build_field();
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'd0; t_sel = 4'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid",  32'(out_valid),  32'd0);
    chk("rst_out_last",   32'(out_last),   32'd0);
    chk("rst_out_parity", 32'(out_parity), 32'd0);
    chk("rst_out_data",   32'(out_data),   32'd0);
    chk("rst_len_err",    32'(len_err),    32'd0);
    chk("rst_in_ready",   32'(in_ready),   32'd1);
    @(posedge clk); #1;
    set_mode(0);

    // Impulse: parity equals g15..g0, no gaps.
    blk[0] = 8'h01;
    send(1, 8, 0, 0, 1);
    drain();
    chk("impulse_span", 32'(last_cyc - first_cyc), 32'd16);

    // All-zero maximum-length block.
    for (int i = 0; i < 239; i++) blk[i] = 8'h00;
    send(239, 8, 0, 0, 1);
    drain();
    chk("zero_span", 32'(last_cyc - first_cyc), 32'd254);

    // Random full-strength blocks back to back (syndromes checked).
    for (int b = 0; b < 3; b++) begin
      n = $urandom_range(1, 239);
      for (int i = 0; i < n; i++) blk[i] = 8'($urandom);
      send(n, 8, 0, 0, 1);
    end
    drain();

    // Puncturing, pass-through and clamping on one 36-symbol block.
    for (int i = 0; i < 36; i++) blk[i] = 8'($urandom);
    send(36, 8, 0, 0, 1);
    send(36, 4, 0, 0, 1);
    send(36, 0, 0, 0, 1);
    send(36, 15, 0, 0, 1);
    drain();

    // Backpressure and input gaps.
    set_mode(1);
    for (int b = 0; b < 3; b++) begin
      n = $urandom_range(1, 60);
      for (int i = 0; i < n; i++) blk[i] = 8'($urandom);
      send(n, $urandom_range(0, 8), 1, 0, 1);
    end
    drain();
    set_mode(0);

    // Length error on symbol 240.
    for (int i = 0; i < 240; i++) blk[i] = 8'($urandom);
    send(240, 8, 0, 1, 1);
    drain();
    chk("len_pulses", 32'(len_pulses), 32'd1);

    // Reset after the 5th parity symbol, then a clean impulse block.
    mon_en = 1'b0;
    blk[0] = 8'h01;
    send(1, 8, 0, 0, 0);
    pc = 0; guard = 0;
    while (pc < 5 && guard < 200) begin
      @(negedge clk); guard++;
      if (out_valid && out_parity && out_ready) pc++;
    end
    chk("reset_parity_seen", 32'(pc), 32'd5);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready",  32'(in_ready),  32'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    blk[0] = 8'h01;
    send(1, 8, 0, 0, 1);
    drain();
    chk("impulse2_span", 32'(last_cyc - first_cyc), 32'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
